// File: rtl/simple_latch_pkg.sv
// simple_latch_pkg
// Shared definitions for the latch reader slice: default sizing, the
// capture-entry layout and a helper that gives the stored entry width.
//
// Optional feature macro: SIMPLE_LATCH_READER_TIMESTAMP_EN
//   When defined, every captured entry also carries a cycle timestamp.
package simple_latch_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

`ifdef SIMPLE_LATCH_READER_TIMESTAMP_EN
  localparam int DEFAULT_TS_W = 16;

  // One FIFO entry at default sizing: captured value plus capture-cycle stamp.
  typedef struct packed {
    logic [DEFAULT_WIDTH-1:0] data;
    logic [DEFAULT_TS_W-1:0]  ts;
  } entry_t;
`else
  // One FIFO entry at default sizing: captured value only.
  typedef struct packed {
    logic [DEFAULT_WIDTH-1:0] data;
  } entry_t;
`endif

  // Width of one stored entry for arbitrary sizing (ts_w = 0 when no stamp).
  function automatic int entry_width(input int width, input int ts_w);
    return width + ts_w;
  endfunction

endpackage

// File: rtl/simple_latch_fifo_mem.sv
// simple_latch_fifo_mem
// DEPTH x ENTRY_W register array used as FIFO storage. One synchronous
// write port and one asynchronous read port, so the FIFO head can be
// presented first-word-fall-through. Contents clear on reset so the head
// reads as zero until something is written.
//
// Ports:
//   clock    in   system clock, rising edge
//   reset    in   synchronous, active-high; clears every entry
//   wr_en    in   write wr_data at wr_addr on this edge
//   wr_addr  in   ADDR_W write address
//   wr_data  in   ENTRY_W write data
//   rd_addr  in   ADDR_W read address
//   rd_data  out  ENTRY_W entry at rd_addr (combinational)
module simple_latch_fifo_mem #(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 8,
  parameter int ADDR_W  = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [ENTRY_W-1:0] rd_data
);

  logic [ENTRY_W-1:0] mem_reg [DEPTH];
  logic [DEPTH-1:0]   wr_sel;

  // One-hot write select, one bit per entry.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
      assign wr_sel[gi] = wr_en && (wr_addr == ADDR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (reset) begin
        mem_reg[i] <= '0;
      end else if (wr_sel[i]) begin
        mem_reg[i] <= wr_data;
      end
    end
  end

  assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/simple_latch_reader.sv
// simple_latch_reader
// Samples a latch output every enabled cycle, captures each new value
// (change detection) into a small FIFO and presents captured values to a
// downstream consumer over a valid/ready stream, first-word-fall-through.
//
// Optional feature macro: SIMPLE_LATCH_READER_TIMESTAMP_EN
//   Adds parameter TS_W and output out_ts: a free-running cycle counter value
//   stored with each capture and presented alongside out_data.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   enable     in   sampling enable; no captures while low
//   latch_q    in   WIDTH value of the latch being read
//   out_valid  out  FIFO non-empty; out_data valid
//   out_ready  in   consumer accepts out_data this cycle
//   out_data   out  WIDTH oldest captured value
//   count      out  PTR_W+1 FIFO occupancy, 0..DEPTH
//   out_ts     out  TS_W capture stamp of out_data (macro builds only)
//   overflow   out  sticky; a capture was dropped because the FIFO was full
module simple_latch_reader
  import simple_latch_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
`ifdef SIMPLE_LATCH_READER_TIMESTAMP_EN
  parameter int TS_W  = DEFAULT_TS_W,
`endif
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] latch_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [PTR_W:0]   count,
`ifdef SIMPLE_LATCH_READER_TIMESTAMP_EN
  output logic [TS_W-1:0]  out_ts,
`endif
  output logic             overflow
);

`ifdef SIMPLE_LATCH_READER_TIMESTAMP_EN
  localparam int ENTRY_W = entry_width(WIDTH, TS_W);
`else
  localparam int ENTRY_W = entry_width(WIDTH, 0);
`endif

  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W:0]     count_reg;
  logic [PTR_W:0]     count_next;
  logic [WIDTH-1:0]   last_val_reg;
  logic               primed_reg;
  logic               overflow_reg;

  logic               full;
  logic               capture;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;

  assign full      = (count_reg == (PTR_W+1)'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign pop       = out_valid && out_ready;

  // A fresh enable window always captures its first sample, even if unchanged.
  assign capture   = enable && (!primed_reg || (latch_q != last_val_reg));

  // A same-edge pop frees a slot, so a capture into a full FIFO still lands.
  assign push      = capture && (!full || pop);

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + (PTR_W+1)'(1);
      2'b01:   count_next = count_reg - (PTR_W+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      last_val_reg <= '0;
      primed_reg   <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      // DEPTH is a power of two, so pointers wrap naturally.
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      // last_val follows every capture, including a dropped one, so a value
      // lost to overflow is not picked up again on the next cycle.
      if (capture) begin
        last_val_reg <= latch_q;
      end
      // While enabled, either primed was already set or this edge captures.
      primed_reg <= enable;
      if (capture && !push) begin
        overflow_reg <= 1'b1;
      end
    end
  end

`ifdef SIMPLE_LATCH_READER_TIMESTAMP_EN
  logic [TS_W-1:0] ts_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      ts_reg <= '0;
    end else begin
      ts_reg <= ts_reg + TS_W'(1);
    end
  end

  assign wr_entry = {latch_q, ts_reg};
  assign out_data = rd_entry[ENTRY_W-1 -: WIDTH];
  assign out_ts   = rd_entry[TS_W-1:0];
`else
  assign wr_entry = latch_q;
  assign out_data = rd_entry;
`endif

  assign count    = count_reg;
  assign overflow = overflow_reg;

  simple_latch_fifo_mem #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W),
    .ADDR_W  (PTR_W)
  ) u_mem (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (push),
    .wr_addr (wr_ptr_reg),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr_reg),
    .rd_data (rd_entry)
  );

endmodule
